ul_nibble_seq: RTL and testbench

//  - Bit-serial-by-nibble sequencer for the 4-bit logic unit ul4 (AND/OR/XOR/NOT).
//  - Performs one W-bit logic operation (W = 4*NIBBLES) by feeding one nibble per clock through a single ul4.
//  - Assembles the W-bit result, then returns it on a valid/ready response port.
//  - Sits between the ALU command front end and the logic-unit datapath, so wide logic ops reuse the one 4-bit unit.

---
 rtl/ul_nibble_seq_pkg.sv | 21 ++
 rtl/ul_nibble_seq_ul4.sv | 22 ++
 rtl/ul_nibble_seq.sv | 135 +++++++++++++
 tb/tb_ul_nibble_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ul_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial logic sequencer: ul4 opcodes,
// FSM state encoding and the index-width helper.
package ul_nibble_seq_pkg;

  localparam logic [1:0] UL_AND = 2'b00;
  localparam logic [1:0] UL_OR  = 2'b01;
  localparam logic [1:0] UL_XOR = 2'b10;
  localparam logic [1:0] UL_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-nibble sequencer still needs a 1-bit index register.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ul_nibble_seq_ul4.sv
// 4-bit logic unit: AND, OR, XOR or NOT A, selected by S.
module ul_nibble_seq_ul4
  import ul_nibble_seq_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] S,
  output logic [3:0] Out
);

  always_comb begin
    Out = 4'h0;
    case (S)
      UL_AND:  Out = A & B;
      UL_OR:   Out = A | B;
      UL_XOR:  Out = A ^ B;
      UL_NOT:  Out = ~A;
      default: Out = 4'h0;
    endcase
  end

endmodule

// File: rtl/ul_nibble_seq.sv
// Runs one W-bit logic operation through a single 4-bit ul4, one nibble per
// clock, and returns the assembled result on a valid/ready response port.
module ul_nibble_seq
  import ul_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [1:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_out,
  output logic                 rsp_zero,
  output logic                 busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [W-1:0]     a_reg, b_reg;
  logic [1:0]       op_reg;
  logic [W-1:0]     result_reg, result_next;
  logic             zero_reg, zero_next;

  logic             accept, step, last;
  logic [3:0]       a_nib_arr [NIBBLES];
  logic [3:0]       b_nib_arr [NIBBLES];
  logic [3:0]       a_nib, b_nib, ul_out;

  // Nibble views of the captured operands.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_view
    assign a_nib_arr[gi] = a_reg[4*gi +: 4];
    assign b_nib_arr[gi] = b_reg[4*gi +: 4];
  end

  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_nib = a_nib_arr[i];
        b_nib = b_nib_arr[i];
      end
    end
  end

  ul_nibble_seq_ul4 u_ul4 (
    .A   (a_nib),
    .B   (b_nib),
    .S   (op_reg),
    .Out (ul_out)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (idx_reg == IDX_LAST) begin
          last       = 1'b1;
          idx_next   = '0;
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        idx_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Each result nibble has its own write enable; a new request clears all of them.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_result_nib
    assign result_next[4*gi +: 4] =
      accept                               ? 4'h0   :
      (step && (idx_reg == IDX_W'(gi)))    ? ul_out :
                                             result_reg[4*gi +: 4];
  end

  // The zero flag looks at the fully assembled word, including the nibble being written.
  assign zero_next = accept ? 1'b0 : (last ? ~|result_next : zero_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= UL_AND;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      if (accept) begin
        a_reg  <= req_a;
        b_reg  <= req_b;
        op_reg <= req_op;
      end
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_out   = result_reg;
  assign rsp_zero  = zero_reg;

endmodule

// File: tb/tb_ul_nibble_seq.sv
// Scoreboard bench for ul_nibble_seq with NIBBLES=4: stimulus pushes expected
// results, a negedge monitor pops and compares on each response handshake.
module tb_ul_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic [1:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_out;
  logic         rsp_zero;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_out_q[$];
  logic         exp_zero_q[$];

  ul_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every response handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_out_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_out), 32'hDEAD_0000);
      end else begin
        logic [W-1:0] eo;
        logic         ez;
        eo = exp_out_q.pop_front();
        ez = exp_zero_q.pop_front();
        chk("rsp_out", 32'(rsp_out), 32'(eo));
        chk("rsp_zero", 32'(rsp_zero), 32'(ez));
      end
    end
  end

  // Issue one request, push its expectation at acceptance and check response latency.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] exp, input bit mutate);
    int waits;
    int lat;
    @(posedge clk); #1;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_out_q.push_back(exp);
    exp_zero_q.push_back(exp == '0);
    if (mutate) begin
      req_a = W'($urandom);
      req_b = W'($urandom);
      req_op = 2'(op + 2'd1);
    end
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(NIB));
  endtask

  initial begin
    int waits;
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    do_req(16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0);
    do_req(16'hA5C3, 16'hA5C3, 2'b10, 16'h0000, 1'b0);
    do_req(16'h1234, 16'h8001, 2'b01, 16'h9235, 1'b0);
    do_req(16'h0F0F, W'($urandom), 2'b11, 16'hF0F0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_after_rsp_out", 32'(rsp_out), 32'hF0F0);

    // Backpressure with a second request waiting.
    rsp_ready = 1'b0;
    do_req(16'h00FF, 16'h0F0F, 2'b01, 16'h0FFF, 1'b0);
    req_a = 16'h3C3C; req_b = 16'hFFFF; req_op = 2'b10; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_out", 32'(rsp_out), 32'h0FFF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bubble_req_ready", 32'(req_ready), 32'd1);
    chk("bubble_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("second_accepted_busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    exp_out_q.push_back(16'hC3C3);
    exp_zero_q.push_back(1'b0);
    waits = 0;
    while (!rsp_valid && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("second_latency", 32'(waits), 32'(NIB));

    // Reset while RUN is at idx=2: state clears immediately, nothing is reported.
    @(posedge clk); #1;
    req_a = 16'hFFFF; req_b = 16'hFFFF; req_op = 2'b00; req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrun_req_ready", 32'(req_ready), 32'd1);
    chk("midrun_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_rsp_out", 32'(rsp_out), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    do_req(16'hFFFF, 16'h00FF, 2'b00, 16'h00FF, 1'b0);

    waits = 0;
    while (exp_out_q.size() != 0 && waits < 50) begin
      @(posedge clk);
      waits++;
    end
    chk("scoreboard_drained", 32'(exp_out_q.size()), 32'd0);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
